// File: rtl/strided_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strided_buf_pkg
// Description : Shared definitions for the strided, banked activation buffer:
//               shape-word field layout, bank depth and the read-scheduler
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package strided_buf_pkg;

    // Shape word layout: [8:0]=w, [17:9]=h, [24:18]=n_c
    localparam int W_LSB      = 0;
    localparam int W_BITS     = 9;
    localparam int H_LSB      = 9;
    localparam int H_BITS     = 9;
    localparam int NC_LSB     = 18;
    localparam int NC_BITS    = 7;
    localparam int SHAPE_BITS = 25;

    localparam int N_BUF_ENTRIES = 512;

    // Column-group index width: ceil(511/N_BUF_X) fits in 7 bits for N_BUF_X>=5
    localparam int XQ_BITS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } rd_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage
`default_nettype wire

// File: rtl/strided_rd_lane_mask.sv
`default_nettype none
// ============================================================================
// Module      : strided_rd_lane_mask
// Description : Combinational lane mask for one column group. All lanes are
//               valid except on the last group, where only the lanes that
//               still fall inside the tile width are set.
// Ports       : w        in  tile width
//               xq       in  column-group index
//               n_xq     in  number of column groups (ceil(w/N_BUF_X))
//               lane_msk out valid-lane mask, bit i = bank i
// Revision    : 1.0 - initial release
// ============================================================================
module strided_rd_lane_mask
    import strided_buf_pkg::*;
#(
    parameter int N_BUF_X = 5
) (
    input  logic [W_BITS-1:0]  w,
    input  logic [XQ_BITS-1:0] xq,
    input  logic [XQ_BITS-1:0] n_xq,
    output logic [N_BUF_X-1:0] lane_msk
);

    logic [15:0] x0;
    logic [15:0] rem;

    always_comb begin
        x0       = 16'(xq) * 16'(N_BUF_X);
        rem      = 16'(w) - x0;
        lane_msk = '1;
        if (xq == n_xq - XQ_BITS'(1)) begin
            for (int i = 0; i < N_BUF_X; i++) begin
                lane_msk[i] = (16'(i) < rem);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/strided_buffer_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : strided_buffer_rd_sched
// Description : Read-side scheduler for the strided, banked activation
//               buffer. Counts completed tiles from the writer toggle, then
//               issues one linear bank address per cycle for each tile in
//               (c, y, xq) order with c fastest. Valid, lane mask and last
//               are delayed by RD_LAT to line up with BRAM read data.
// Ports       : clk, rstn (sync, active-low), clr (sync soft clear)
//               shape    in  [8:0]=w [17:9]=h [24:18]=n_c, sampled at tile start
//               tog      in  writer tile-complete toggle
//               out_rdy  in  consumer credit at issue time
//               rdaddr   out per-bank read address (all lanes equal)
//               rd_vld   out bank data valid
//               lane_msk out valid lanes of the beat
//               last     out final beat of the tile
//               busy     out FSM not idle
//               err_ovf  out sticky: tile arrived with two already pending
//               out_stall_cnt/tile_cnt out (only with STRIDED_RD_SCHED_PERF_EN)
// Config      : STRIDED_RD_SCHED_PERF_EN adds stall and tile counters.
// Revision    : 1.0 - initial release
// ============================================================================
module strided_buffer_rd_sched
    import strided_buf_pkg::*;
#(
    parameter int N_BUF_X    = 5,
    parameter int B_BUF_ADDR = 9,
    parameter int B_COORD    = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr,
    input  logic [SHAPE_BITS-1:0]          shape,
    input  logic                           tog,
    input  logic                           out_rdy,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  rdaddr,
    output logic                           rd_vld,
    output logic [N_BUF_X-1:0]             lane_msk,
    output logic                           last,
    output logic                           busy,
    output logic                           err_ovf
`ifdef STRIDED_RD_SCHED_PERF_EN
    ,
    output logic [31:0]                    out_stall_cnt,
    output logic [15:0]                    tile_cnt
`endif
);

    // The w/h shape fields are one bit wider than the nominal coordinate width
    localparam int COORD_BITS = B_COORD + 1;

    localparam logic [W_BITS-1:0] NX_W    = W_BITS'(N_BUF_X);
    localparam logic [2:0]        DR_LAST = 3'(RD_LAT - 1);

    logic [1:0]             state;
    logic                   tog_d;
    logic [1:0]             pending;
    logic [B_BUF_ADDR-1:0]  base;
    logic [B_BUF_ADDR-1:0]  addr;
    logic [W_BITS-1:0]      w_r;
    logic [COORD_BITS-1:0]  h_r;
    logic [NC_BITS-1:0]     nc_r;
    logic [W_BITS-1:0]      rem;
    logic [XQ_BITS-1:0]     nxq;
    logic [NC_BITS-1:0]     c_cnt;
    logic [COORD_BITS-1:0]  y_cnt;
    logic [XQ_BITS-1:0]     xq_cnt;
    logic [2:0]             dcnt;

    logic [RD_LAT-1:0]      vld_p;
    logic [RD_LAT-1:0]      last_p;
    logic [N_BUF_X-1:0]     msk_p [RD_LAT];

    logic [N_BUF_X-1:0]     cur_msk;
    logic                   arrival;
    logic                   issue;
    logic                   c_last;
    logic                   y_last;
    logic                   xq_last;
    logic                   tile_last;
    logic                   skip;
    logic                   finish;
    logic                   start;

    assign arrival   = tog ^ tog_d;
    assign issue     = (state == ST_ISSUE) && out_rdy;
    assign c_last    = (c_cnt == nc_r - NC_BITS'(1));
    assign y_last    = (y_cnt == h_r - COORD_BITS'(1));
    assign xq_last   = (xq_cnt == nxq - XQ_BITS'(1));
    assign tile_last = issue && c_last && y_last && xq_last;
    assign skip      = (state == ST_LOAD) &&
                       ((w_r == '0) || (h_r == '0) || (nc_r == '0));
    assign finish    = tile_last || skip;
    // A new tile may start from IDLE or straight out of a completed DRAIN
    assign start     = (pending != 2'd0) &&
                       ((state == ST_IDLE) ||
                        ((state == ST_DRAIN) && (dcnt == DR_LAST)));

    strided_rd_lane_mask #(
        .N_BUF_X (N_BUF_X)
    ) u_lane_mask (
        .w        (w_r),
        .xq       (xq_cnt),
        .n_xq     (nxq),
        .lane_msk (cur_msk)
    );

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state   <= ST_IDLE;
            tog_d   <= tog;       // reset-time level is not a tile edge
            pending <= '0;
            err_ovf <= 1'b0;
            base    <= '0;
            addr    <= '0;
            w_r     <= '0;
            h_r     <= '0;
            nc_r    <= '0;
            rem     <= '0;
            nxq     <= '0;
            c_cnt   <= '0;
            y_cnt   <= '0;
            xq_cnt  <= '0;
            dcnt    <= '0;
        end else begin
            tog_d <= tog;

            // Arrival and finish in the same cycle cancel out
            if (arrival && !finish) begin
                if (pending == 2'd2) begin
                    err_ovf <= 1'b1;
                end else begin
                    pending <= pending + 2'd1;
                end
            end else if (finish && !arrival) begin
                pending <= pending - 2'd1;
            end

            if (start) begin
                w_r   <= shape[W_LSB +: W_BITS];
                h_r   <= shape[H_LSB +: COORD_BITS];
                nc_r  <= shape[NC_LSB +: NC_BITS];
                rem   <= shape[W_LSB +: W_BITS];
                nxq   <= '0;
                state <= ST_LOAD;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (skip) begin
                            state <= ST_IDLE;
                        end else if (rem > NX_W) begin
                            // ceil(w/N_BUF_X) by repeated subtraction
                            rem <= rem - NX_W;
                            nxq <= nxq + XQ_BITS'(1);
                        end else begin
                            nxq    <= nxq + XQ_BITS'(1);
                            c_cnt  <= '0;
                            y_cnt  <= '0;
                            xq_cnt <= '0;
                            addr   <= base;
                            state  <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (issue) begin
                            addr <= addr + B_BUF_ADDR'(1);
                            if (c_last) begin
                                c_cnt <= '0;
                                if (y_last) begin
                                    y_cnt  <= '0;
                                    xq_cnt <= xq_cnt + XQ_BITS'(1);
                                end else begin
                                    y_cnt <= y_cnt + COORD_BITS'(1);
                                end
                            end else begin
                                c_cnt <= c_cnt + NC_BITS'(1);
                            end
                            if (tile_last) begin
                                // Next tile starts right after the last address
                                base  <= addr + B_BUF_ADDR'(1);
                                dcnt  <= '0;
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (dcnt == DR_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            dcnt <= dcnt + 3'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Beat qualifiers travel alongside the BRAM read latency
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            vld_p  <= '0;
            last_p <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                msk_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= issue;
            last_p[0] <= tile_last;
            msk_p[0]  <= issue ? cur_msk : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                msk_p[i]  <= msk_p[i-1];
            end
        end
    end

    assign rdaddr   = {N_BUF_X{addr}};
    assign rd_vld   = vld_p[RD_LAT-1];
    assign last     = last_p[RD_LAT-1];
    assign lane_msk = msk_p[RD_LAT-1];
    assign busy     = (state != ST_IDLE);

`ifdef STRIDED_RD_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            out_stall_cnt <= '0;
            tile_cnt      <= '0;
        end else begin
            if ((state == ST_ISSUE) && !out_rdy) begin
                out_stall_cnt <= out_stall_cnt + 32'd1;
            end
            if (finish) begin
                tile_cnt <= tile_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
